// File: rtl/scc_i2s_tx_if.sv
// Sample/control and serial-output bundle of the SCC I2S transmitter.
// master = transmitter side, slave = mixer/DAC side.
interface scc_i2s_tx_if;
  logic [10:0] sound_in;
  logic        mute;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        sample_valid;

  modport master (
    input  sound_in,
    input  mute,
    output i2s_bclk,
    output i2s_lrclk,
    output i2s_data,
    output sample_valid
  );

  modport slave (
    output sound_in,
    output mute,
    input  i2s_bclk,
    input  i2s_lrclk,
    input  i2s_data,
    input  sample_valid
  );
endinterface

// File: rtl/scc_i2s_tx.sv
// SCC mix -> 16-bit PCM -> Philips I2S (32-bit slots, mono on L and R).
// Optional anti-alias IIR ahead of decimation: define SCC_I2S_LPF_EN.
module scc_i2s_tx #(
  parameter int CLK_DIV   = 7,
  parameter int LPF_SHIFT = 4
) (
  input logic         clk,
  input logic         nreset,
  scc_i2s_tx_if.master bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || LPF_SHIFT < 1 || LPF_SHIFT > 8) begin : g_bad_cfg
    $error("scc_i2s_tx: CLK_DIV or LPF_SHIFT out of range");
  end

  logic [DW-1:0] div_cnt;
  logic          bclk;
  logic          lrclk;
  logic          data;
  logic          valid;
  logic [5:0]    bit_cnt;
  logic [15:0]   pcm_reg;

  logic [15:0]   pcm;
  logic [15:0]   src;
  logic          tick;
  logic          fall;
  logic          wrap;
  logic [5:0]    bit_nxt;
  logic [4:0]    slot_m1;
  logic [3:0]    bit_idx;
  logic          data_nxt;

  assign pcm = {~bus.sound_in[10], bus.sound_in[9:0], 5'b0};

  assign tick    = (div_cnt == DIV_TC);
  assign fall    = tick & bclk;
  assign bit_nxt = bit_cnt + 6'd1;
  assign wrap    = fall & (bit_cnt == 6'd63);

  // Slots 1..16 of either half carry the word; slot 0 underflows to 31.
  assign slot_m1  = bit_nxt[4:0] - 5'd1;
  assign bit_idx  = ~slot_m1[3:0];
  assign data_nxt = ~slot_m1[4] & pcm_reg[bit_idx];

`ifdef SCC_I2S_LPF_EN
  logic signed [15:0] y;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [16:0] y_sum;

  assign diff  = $signed({pcm[15], pcm}) - $signed({y[15], y});
  assign step  = diff >>> LPF_SHIFT;
  assign y_sum = $signed({y[15], y}) + step;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      y <= '0;
    end else begin
      y <= y_sum[15:0];
    end
  end

  assign src = y;
`else
  assign src = pcm;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
      data    <= 1'b0;
      valid   <= 1'b0;
      pcm_reg <= '0;
    end else begin
      valid <= wrap;
      if (tick) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[5];
        data    <= data_nxt;
      end
      if (wrap) begin
        pcm_reg <= bus.mute ? 16'h0000 : src;
      end
    end
  end

  assign bus.i2s_bclk     = bclk;
  assign bus.i2s_lrclk    = lrclk;
  assign bus.i2s_data     = data;
  assign bus.sample_valid = valid;

endmodule
